// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg: shared types for the full-speed USB receive sequencer.
// Line states are encoded as {dp, dn}, so a raw sample casts directly.
package usb_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    ACTIVE,
    EOP,
    ERROR
  } rx_state_t;

  typedef enum logic [1:0] {
    SE0 = 2'b00,
    K   = 2'b01,
    J   = 2'b10,
    SE1 = 2'b11
  } line_state_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_STUFF = 2'd1,
    ERR_SE1   = 2'd2,
    ERR_ALIGN = 2'd3
  } rx_err_t;

  localparam int STUFF_LIMIT = 6;

  function automatic line_state_t line_of(
    input logic dp,
    input logic dn
  );
    return line_state_t'({dp, dn});
  endfunction

endpackage

// File: rtl/usb_rx_unstuff.sv
// usb_rx_unstuff: ones counting, stuffed-bit drop / stuff error detection,
// and the registered bit-serial output stage.
module usb_rx_unstuff
  import usb_rx_pkg::*;
(
  input  logic clk12_i,
  input  logic rst_ni,
  input  logic en,
  input  logic clr,
  input  logic din,
  output logic emit,
  output logic stuff_err,
  output logic data,
  output logic valid
);

  logic [2:0] ones_q;
  logic       at_limit;

  assign at_limit  = (ones_q == 3'(STUFF_LIMIT));
  assign emit      = en & ~at_limit;
  assign stuff_err = en & at_limit & din;

  always_ff @(posedge clk12_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ones_q <= 3'd0;
      data   <= 1'b0;
      valid  <= 1'b0;
    end else begin
      valid <= emit;
      if (emit) data <= din;
      // The closing 1 of SYNC counts toward the stuffing run.
      if (clr) begin
        ones_q <= 3'd1;
      end else if (en) begin
        ones_q <= (at_limit | ~din) ? 3'd0 : ones_q + 3'd1;
      end
    end
  end

endmodule

// File: rtl/usb_rx_sequencer.sv
// usb_rx_sequencer: SYNC / unstuff / EOP sequencer driving an external NRZI decoder.
// Build option: USB_RX_STRICT_SYNC_EN requires exactly 7 SYNC zeros.
module usb_rx_sequencer
  import usb_rx_pkg::*;
#(
  parameter int SYNC_MIN_ZEROS = 5,
  parameter int EOP_MAX_SE0    = 3
) (
  input  logic       clk12_i,
  input  logic       rst_ni,
  input  logic       dp_i,
  input  logic       dn_i,
  input  logic       nrzi_bit_i,
  output logic       nrzi_rst_o,
  output logic       rx_active_o,
  output logic       data_o,
  output logic       valid_o,
  output logic       eop_o,
  output logic       err_o,
  output logic [1:0] err_code_o
);

  localparam int SE0W = $clog2(EOP_MAX_SE0 + 1);

  rx_state_t   state_q, state_d;
  line_state_t ls_q;
  logic [2:0]  zero_q, zero_d;
  logic [SE0W-1:0] se0_q, se0_d;
  logic [2:0]  bcnt_q, bcnt_d;
  logic        us_en, us_clr;
  logic        emit, stuff_err;
  logic        sync_ok;
  logic        eop_d, err_d, nrst_d;
  rx_err_t     code_d;

`ifdef USB_RX_STRICT_SYNC_EN
  assign sync_ok = (zero_q == 3'd7);
`else
  assign sync_ok = (zero_q >= 3'(SYNC_MIN_ZEROS));
`endif

  usb_rx_unstuff u_unstuff (
    .clk12_i   (clk12_i),
    .rst_ni    (rst_ni),
    .en        (us_en),
    .clr       (us_clr),
    .din       (nrzi_bit_i),
    .emit      (emit),
    .stuff_err (stuff_err),
    .data      (data_o),
    .valid     (valid_o)
  );

  always_comb begin
    state_d = state_q;
    zero_d  = zero_q;
    se0_d   = se0_q;
    bcnt_d  = bcnt_q;
    us_en   = 1'b0;
    us_clr  = 1'b0;
    eop_d   = 1'b0;
    err_d   = 1'b0;
    nrst_d  = 1'b0;
    code_d  = ERR_NONE;
    unique case (state_q)
      IDLE: begin
        zero_d = 3'd0;
        if (ls_q == K) begin
          state_d = SYNC;
          zero_d  = 3'd1;
        end
      end
      SYNC: begin
        if (ls_q == SE0 || ls_q == SE1) begin
          state_d = IDLE;
        end else if (!nrzi_bit_i) begin
          if (zero_q == 3'd7) state_d = IDLE;
          else zero_d = zero_q + 3'd1;
        end else if (sync_ok) begin
          state_d = ACTIVE;
          us_clr  = 1'b1;
          bcnt_d  = 3'd0;
        end else begin
          state_d = IDLE;
        end
      end
      ACTIVE: begin
        if (ls_q == SE1) begin
          state_d = ERROR;
          err_d   = 1'b1;
          code_d  = ERR_SE1;
        end else if (ls_q == SE0) begin
          state_d = EOP;
          se0_d   = SE0W'(1);
        end else begin
          us_en = 1'b1;
          if (stuff_err) begin
            state_d = ERROR;
            err_d   = 1'b1;
            code_d  = ERR_STUFF;
          end else if (emit) begin
            bcnt_d = bcnt_q + 3'd1;
          end
        end
      end
      EOP: begin
        unique case (ls_q)
          SE0: begin
            if (se0_q == SE0W'(EOP_MAX_SE0)) begin
              state_d = ERROR;
              err_d   = 1'b1;
              code_d  = ERR_ALIGN;
            end else begin
              se0_d = se0_q + SE0W'(1);
            end
          end
          J: begin
            state_d = IDLE;
            eop_d   = 1'b1;
            nrst_d  = 1'b1;
            code_d  = (bcnt_q != 3'd0) ? ERR_ALIGN : ERR_NONE;
          end
          default: begin
            state_d = ERROR;
            err_d   = 1'b1;
            code_d  = ERR_SE1;
          end
        endcase
      end
      ERROR: begin
        if (ls_q == J) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == ERROR) nrst_d = 1'b1;
  end

  always_ff @(posedge clk12_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      ls_q        <= J;
      zero_q      <= 3'd0;
      se0_q       <= '0;
      bcnt_q      <= 3'd0;
      nrzi_rst_o  <= 1'b1;
      rx_active_o <= 1'b0;
      eop_o       <= 1'b0;
      err_o       <= 1'b0;
      err_code_o  <= 2'd0;
    end else begin
      state_q     <= state_d;
      ls_q        <= line_of(dp_i, dn_i);
      zero_q      <= zero_d;
      se0_q       <= se0_d;
      bcnt_q      <= bcnt_d;
      nrzi_rst_o  <= nrst_d;
      rx_active_o <= (state_d == ACTIVE) || (state_d == EOP);
      eop_o       <= eop_d;
      err_o       <= err_d;
      err_code_o  <= code_d;
    end
  end

endmodule

// File: tb/tb_usb_rx_sequencer.sv
// tb_usb_rx_sequencer: scoreboard bench with an NRZI encoder/decoder model.
// Expected bits and EOP/error events are queued at drive time.
module tb_usb_rx_sequencer;
  import usb_rx_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dp = 1'b1;
  logic       dn = 1'b0;
  logic       nrzi_bit;
  logic       nrzi_rst, rx_active, data, valid, eop, err;
  logic [1:0] code;

  int n_chk = 0;
  int n_fail = 0;
  logic       bitq[$];
  logic [2:0] evq[$];
  logic       lvl = 1'b1;
  int         ones = 0;
  logic       dec_prev;

  always #5 clk = ~clk;

  usb_rx_sequencer #(
    .SYNC_MIN_ZEROS (5),
    .EOP_MAX_SE0    (3)
  ) dut (
    .clk12_i     (clk),
    .rst_ni      (rst_n),
    .dp_i        (dp),
    .dn_i        (dn),
    .nrzi_bit_i  (nrzi_bit),
    .nrzi_rst_o  (nrzi_rst),
    .rx_active_o (rx_active),
    .data_o      (data),
    .valid_o     (valid),
    .eop_o       (eop),
    .err_o       (err),
    .err_code_o  (code)
  );

  // External NRZI decoder: 1 = no transition, previous level reset to J.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_prev <= 1'b1;
      nrzi_bit <= 1'b1;
    end else if (nrzi_rst) begin
      dec_prev <= 1'b1;
      nrzi_bit <= 1'b1;
    end else begin
      nrzi_bit <= (dp == dec_prev);
      dec_prev <= dp;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic line(input logic p, input logic n);
    dp = p;
    dn = n;
    @(posedge clk);
    #1;
  endtask

  task automatic tx_bit(input logic b, input logic exp);
    if (!b) lvl = ~lvl;
    if (exp) bitq.push_back(b);
    line(lvl, ~lvl);
  endtask

  task automatic tx_sync(input int zeros);
    lvl = 1'b1;
    repeat (zeros) tx_bit(1'b0, 1'b0);
    tx_bit(1'b1, 1'b0);
    ones = 1;
  endtask

  task automatic tx_byte(input logic [7:0] b, input logic stuff);
    for (int i = 0; i < 8; i++) begin
      tx_bit(b[i], 1'b1);
      ones = b[i] ? ones + 1 : 0;
      if (stuff && ones == 6) begin
        tx_bit(1'b0, 1'b0);
        ones = 0;
      end
    end
  endtask

  task automatic tx_eop(input int n_se0);
    repeat (n_se0) line(1'b0, 1'b0);
    lvl = 1'b1;
    line(1'b1, 1'b0);
  endtask

  task automatic drain(input string tag);
    lvl = 1'b1;
    repeat (5) line(1'b1, 1'b0);
    chk({tag, "_bitq"}, bitq.size(), 0);
    chk({tag, "_evq"}, evq.size(), 0);
    chk({tag, "_act"}, rx_active, 0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (valid) begin
        if (bitq.size() == 0) chk("bit_extra", bitq.size(), 1);
        else chk("bit", data, bitq.pop_front());
      end
      if (eop || err) begin
        chk("pulse_excl", eop & err, 0);
        chk("act_fall", rx_active, 0);
        if (evq.size() == 0) chk("evt_extra", evq.size(), 1);
        else chk("evt", {err, code}, evq.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_nrzi", nrzi_rst, 1);
    chk("rst_act", rx_active, 0);
    chk("rst_valid", valid, 0);
    chk("rst_pulse", {eop, err, code}, 0);
    rst_n = 1'b1;
    #1;
    chk("nrzi_first", nrzi_rst, 1);
    @(posedge clk);
    #1;
    chk("nrzi_drop", nrzi_rst, 0);
    for (int i = 0; i < 4; i++) begin
      line(1'b1, 1'b0);
      chk("idle_nrzi", nrzi_rst, 0);
      chk("idle_act", rx_active | valid, 0);
    end

    tx_sync(7);
    tx_byte(8'hA5, 1'b1);
    chk("a5_act", rx_active, 1);
    evq.push_back(3'b000);
    tx_eop(2);
    chk("eop_nrzi0", nrzi_rst, 0);
    line(1'b1, 1'b0);
    chk("eop_nrzi1", nrzi_rst, 1);
    line(1'b1, 1'b0);
    chk("eop_nrzi2", nrzi_rst, 0);
    drain("a5");

    tx_sync(7);
    tx_byte(8'hFF, 1'b1);
    evq.push_back(3'b000);
    tx_eop(2);
    drain("ff");

    tx_sync(7);
    repeat (5) tx_bit(1'b1, 1'b1);
    evq.push_back({1'b1, ERR_STUFF});
    tx_bit(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      line(lvl, ~lvl);
      chk("err_nrzi", nrzi_rst, 1);
      chk("err_act", rx_active, 0);
    end
    line(1'b1, 1'b0);
    chk("err_hold", nrzi_rst, 1);
    line(1'b1, 1'b0);
    chk("err_exit", nrzi_rst, 0);
    drain("stuff");

    tx_sync(7);
    tx_bit(1'b1, 1'b1);
    tx_bit(1'b0, 1'b1);
    tx_bit(1'b1, 1'b1);
    tx_bit(1'b1, 1'b1);
    tx_bit(1'b0, 1'b1);
    evq.push_back({1'b0, ERR_ALIGN});
    tx_eop(2);
    drain("align");

    tx_sync(7);
    tx_byte(8'h3C, 1'b1);
    evq.push_back({1'b1, ERR_ALIGN});
    repeat (12) line(1'b0, 1'b0);
    chk("long_se0_nrzi", nrzi_rst, 1);
    drain("long_se0");
    chk("long_se0_exit", nrzi_rst, 0);
    tx_sync(7);
    tx_byte(8'h5A, 1'b1);
    evq.push_back(3'b000);
    tx_eop(2);
    drain("after_err");

    tx_sync(7);
    repeat (3) tx_bit(1'b0, 1'b1);
    evq.push_back({1'b1, ERR_SE1});
    line(1'b1, 1'b1);
    drain("se1");

    tx_sync(4);
    for (int i = 0; i < 4; i++) begin
      line(1'b1, 1'b0);
      chk("short_sync_act", rx_active, 0);
    end
    drain("short_sync");

    lvl = 1'b1;
    repeat (8) tx_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      line(1'b1, 1'b0);
      chk("zero8_act", rx_active, 0);
    end
    drain("zero8");

`ifdef USB_RX_STRICT_SYNC_EN
    tx_sync(6);
    for (int i = 0; i < 4; i++) begin
      line(1'b1, 1'b0);
      chk("strict6_act", rx_active, 0);
    end
    drain("strict6");
`else
    tx_sync(5);
    tx_byte(8'hC3, 1'b1);
    evq.push_back(3'b000);
    tx_eop(2);
    drain("min_sync");
`endif

    tx_sync(7);
    tx_bit(1'b1, 1'b1);
    tx_bit(1'b0, 1'b1);
    tx_bit(1'b1, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_nrzi", nrzi_rst, 1);
    chk("arst_out", {rx_active, valid, eop, err, code}, 0);
    bitq.delete();
    lvl = 1'b1;
    line(1'b1, 1'b0);
    line(1'b1, 1'b0);
    rst_n = 1'b1;
    drain("arst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
